gpio_pad_ctrl: RTL and testbench
================================

// Module: gpio_pad_ctrl
// PURPOSE
//  Parametrised multi-pin GPIO controller that drives the bidirectional pad-mux cells (I/OE/IE/PU/PD) and conditions the
//  pad inputs (C). Per pin: registered output path with push-pull/open-drain mode, input synchroniser, glitch filter,
//  and rise/fall edge detection with sticky interrupt status. Sits between the GPIO register block and the pad ring.
// PARAMETERS
//  NUM_PINS     8  number of pads controlled
//  SYNC_STAGES  2  input synchroniser depth (>=2)
//  FILT_W       4  glitch-filter length/counter width; filter length 0..2^FILT_W-1 cycles
// PORTS
//  clk_i          in   1         core clock
//  rst_ni         in   1         asynchronous active-low reset
//  out_i          in   NUM_PINS  output data per pin
//  oe_i           in   NUM_PINS  output enable per pin
//  od_i           in   NUM_PINS  1 = open-drain mode, 0 = push-pull
//  ie_i           in   NUM_PINS  input enable per pin
//  pu_i / pd_i    in   NUM_PINS  pull-up / pull-down request
//  filt_en_i      in   NUM_PINS  glitch filter enable per pin
//  filt_len_i     in   FILT_W    filter length in cycles (shared)
//  irq_rise_en_i  in   NUM_PINS  rising-edge interrupt enable
//  irq_fall_en_i  in   NUM_PINS  falling-edge interrupt enable
//  irq_clr_i      in   NUM_PINS  write-1-to-clear pulse for irq status
//  pad_c_i        in   NUM_PINS  pad-cell C (input from pad)
//  pad_i_o        out  NUM_PINS  pad-cell I (data to pad)
//  pad_oe_o/pad_ie_o/pad_pu_o/pad_pd_o  out  NUM_PINS  pad-cell controls
//  in_o           out  NUM_PINS  synchronised, filtered input value
//  irq_status_o   out  NUM_PINS  sticky edge status
//  irq_o          out  1         OR of irq_status_o
// BEHAVIOUR
//  Reset (async, rst_ni=0): all pad_*_o, sync flops, filter counters, in_o, edge history, irq_status_o, irq_o = 0.
//  Output path: all pad controls registered, 1-cycle latency from inputs.
//   push-pull (od=0): pad_i_o<=out_i, pad_oe_o<=oe_i.  open-drain (od=1): pad_i_o<=0, pad_oe_o<=oe_i & ~out_i.
//   pad_ie_o<=ie_i. pu&pd both set: pad_pu_o<=1, pad_pd_o<=0 (pull-up wins); never both driven high.
//  Input path: raw = pad_c_i & pad_ie_o; SYNC_STAGES flop chain -> s.
//   Filter per pin, effective length L = (filt_en && filt_len_i!=0) ? filt_len_i : 1.
//   s==in_o: cnt<=0. s!=in_o: cnt<=cnt+1; when cnt+1 >= L: in_o<=s, cnt<=0.
//   Pad change stable before edge 0 reaches in_o after edge SYNC_STAGES+L. Pulse shorter than L sync'd cycles: dropped.
//   filt_len_i lowered mid-count: >= compare commits next cycle; no counter wrap possible.
//  Edge detect on in_o vs 1-cycle-delayed copy: rise=in_o&~d, fall=~in_o&d.
//   status set if (rise&rise_en)|(fall&fall_en); cleared by irq_clr_i; set and clear same cycle -> set wins.
//   irq_o registered = |next status (same cycle as status bit). Disabling an enable does not clear status.
//  ie_i=0 forces raw=0: a high pin appears as a falling edge after SYNC_STAGES+L cycles (intended; SW masks).
//  Reset asserted mid-filter/mid-irq: everything clears immediately; no edge reported on reset release (in_o, d both 0).
// TESTING
//  T1 reset: rst_ni=0 with random inputs -> all outputs 0; release, pad_c=0 -> no irq for 20 cycles.
//  T2 drive: oe=1,out=1,od=0 -> pad_oe=1,pad_i=1 next cycle; od=1,out=1 -> pad_oe=0,pad_i=0; od=1,out=0 -> pad_oe=1,pad_i=0.
//  T3 pulls: pu=1,pd=1 -> pad_pu=1,pad_pd=0; pu=0,pd=1 -> pad_pd=1.
//  T4 filter: filt_en=1,len=4, 3-cycle high glitch -> in_o stays 0; 6-cycle high -> in_o=1 exactly 2+4 cycles after edge.
//  T5 irq: rise_en=1, pin 0->1 -> status[n]=1,irq_o=1; irq_clr pulse -> 0; clr coincident with new edge -> stays 1.
//  T6 unfiltered latency/ie: filt_en=0, toggle pad_c -> in_o follows after 3 cycles; ie=0 with pad high -> in_o falls, fall irq.

Source files
------------

// File: rtl/gpio_pad_ctrl.sv
// Per-pin GPIO pad controller: registered pad-cell controls, input synchroniser,
// glitch filter and edge-detect interrupt status with write-1-to-clear.
module gpio_pad_ctrl #(
  parameter int NUM_PINS    = 8,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W      = 4
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [NUM_PINS-1:0] out_i,
  input  logic [NUM_PINS-1:0] oe_i,
  input  logic [NUM_PINS-1:0] od_i,
  input  logic [NUM_PINS-1:0] ie_i,
  input  logic [NUM_PINS-1:0] pu_i,
  input  logic [NUM_PINS-1:0] pd_i,
  input  logic [NUM_PINS-1:0] filt_en_i,
  input  logic [FILT_W-1:0]   filt_len_i,
  input  logic [NUM_PINS-1:0] irq_rise_en_i,
  input  logic [NUM_PINS-1:0] irq_fall_en_i,
  input  logic [NUM_PINS-1:0] irq_clr_i,
  input  logic [NUM_PINS-1:0] pad_c_i,
  output logic [NUM_PINS-1:0] pad_i_o,
  output logic [NUM_PINS-1:0] pad_oe_o,
  output logic [NUM_PINS-1:0] pad_ie_o,
  output logic [NUM_PINS-1:0] pad_pu_o,
  output logic [NUM_PINS-1:0] pad_pd_o,
  output logic [NUM_PINS-1:0] in_o,
  output logic [NUM_PINS-1:0] irq_status_o,
  output logic                irq_o
);

  localparam logic [FILT_W:0] CNT_ONE = (FILT_W+1)'(1);

  logic [NUM_PINS-1:0] raw;
  logic [NUM_PINS-1:0] sync_q [SYNC_STAGES];
  logic [NUM_PINS-1:0] s;
  logic [NUM_PINS-1:0] filt;
  logic [NUM_PINS-1:0] in_d_q;
  logic [NUM_PINS-1:0] rise;
  logic [NUM_PINS-1:0] fall;
  logic [NUM_PINS-1:0] status_nxt;

  // Open-drain only ever drives low; pull-up wins when both pulls are requested.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pad_i_o  <= '0;
      pad_oe_o <= '0;
      pad_ie_o <= '0;
      pad_pu_o <= '0;
      pad_pd_o <= '0;
    end else begin
      pad_i_o  <= out_i & ~od_i;
      pad_oe_o <= oe_i & ~(od_i & out_i);
      pad_ie_o <= ie_i;
      pad_pu_o <= pu_i;
      pad_pd_o <= pd_i & ~pu_i;
    end
  end

  assign raw = pad_c_i & pad_ie_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
    end else begin
      sync_q[0] <= raw;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  for (genvar p = 0; p < NUM_PINS; p++) begin : g_filt
    logic [FILT_W-1:0] cnt_q;
    logic              in_q;
    logic [FILT_W:0]   len;
    logic [FILT_W:0]   cnt_inc;

    // >= compare lets a lowered length commit at once instead of wrapping.
    assign len     = (filt_en_i[p] && (filt_len_i != '0)) ? {1'b0, filt_len_i} : CNT_ONE;
    assign cnt_inc = {1'b0, cnt_q} + CNT_ONE;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        cnt_q <= '0;
        in_q  <= 1'b0;
      end else if (s[p] == in_q) begin
        cnt_q <= '0;
      end else if (cnt_inc >= len) begin
        in_q  <= s[p];
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_inc[FILT_W-1:0];
      end
    end

    assign filt[p] = in_q;
  end

  assign in_o = filt;

  assign rise       = filt & ~in_d_q;
  assign fall       = ~filt & in_d_q;
  assign status_nxt = (irq_status_o & ~irq_clr_i) | (rise & irq_rise_en_i) | (fall & irq_fall_en_i);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      in_d_q       <= '0;
      irq_status_o <= '0;
      irq_o        <= 1'b0;
    end else begin
      in_d_q       <= filt;
      irq_status_o <= status_nxt;
      irq_o        <= |status_nxt;
    end
  end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Self-checking bench for gpio_pad_ctrl: directed scenarios plus randomized
// traffic compared against a window-based behavioural model.
module tb_gpio_pad_ctrl;
  localparam int N = 8;
  localparam int S = 2;
  localparam int W = 4;

  logic         clk_i = 1'b0;
  logic         rst_ni = 1'b0;
  logic [N-1:0] out_i, oe_i, od_i, ie_i, pu_i, pd_i, filt_en_i;
  logic [W-1:0] filt_len_i;
  logic [N-1:0] irq_rise_en_i, irq_fall_en_i, irq_clr_i, pad_c_i;
  logic [N-1:0] pad_i_o, pad_oe_o, pad_ie_o, pad_pu_o, pad_pd_o, in_o, irq_status_o;
  logic         irq_o;

  int checks = 0;
  int failures = 0;

  // model state
  logic [N-1:0] m_i, m_oe, m_ie, m_pu, m_pd, m_in, m_d, m_st;
  logic         m_irq;
  logic [N-1:0] m_raw [S];
  logic [15:0]  m_hist [N];

  gpio_pad_ctrl #(.NUM_PINS(N), .SYNC_STAGES(S), .FILT_W(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .out_i(out_i), .oe_i(oe_i), .od_i(od_i), .ie_i(ie_i), .pu_i(pu_i), .pd_i(pd_i),
    .filt_en_i(filt_en_i), .filt_len_i(filt_len_i),
    .irq_rise_en_i(irq_rise_en_i), .irq_fall_en_i(irq_fall_en_i), .irq_clr_i(irq_clr_i),
    .pad_c_i(pad_c_i),
    .pad_i_o(pad_i_o), .pad_oe_o(pad_oe_o), .pad_ie_o(pad_ie_o),
    .pad_pu_o(pad_pu_o), .pad_pd_o(pad_pd_o),
    .in_o(in_o), .irq_status_o(irq_status_o), .irq_o(irq_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic model_reset();
    {m_i, m_oe, m_ie, m_pu, m_pd, m_in, m_d, m_st} = '0;
    m_irq = 1'b0;
    for (int k = 0; k < S; k++) m_raw[k] = '0;
    for (int p = 0; p < N; p++) m_hist[p] = '0;
  endtask

  task automatic set_defaults();
    out_i = '0; oe_i = '0; od_i = '0; ie_i = '1; pu_i = '0; pd_i = '0;
    filt_en_i = '0; filt_len_i = '0;
    irq_rise_en_i = '0; irq_fall_en_i = '0; irq_clr_i = '0; pad_c_i = '0;
  endtask

  // Advance one clock and update the model. A pin's input flips once the last
  // L synchronised samples all disagree with it.
  task automatic step();
    logic [N-1:0] raw, s_seen, rise, fall;
    logic [15:0]  mask;
    int           len;
    @(posedge clk_i);
    #1;
    if (!rst_ni) begin
      model_reset();
      return;
    end
    raw    = pad_c_i & m_ie;
    s_seen = m_raw[S-1];
    rise   = m_in & ~m_d;
    fall   = ~m_in & m_d;
    m_st   = (m_st & ~irq_clr_i) | (rise & irq_rise_en_i) | (fall & irq_fall_en_i);
    m_irq  = |m_st;
    m_d    = m_in;
    for (int p = 0; p < N; p++) begin
      len  = (filt_en_i[p] && filt_len_i != 0) ? int'(filt_len_i) : 1;
      mask = 16'((1 << len) - 1);
      m_hist[p] = {m_hist[p][14:0], s_seen[p]};
      if ((m_hist[p] & mask) == (m_in[p] ? 16'h0 : mask)) m_in[p] = ~m_in[p];
    end
    for (int k = S - 1; k > 0; k--) m_raw[k] = m_raw[k-1];
    m_raw[0] = raw;
    m_i  = out_i & ~od_i;
    m_oe = od_i ? (oe_i & ~out_i) & od_i | (oe_i & ~od_i) : oe_i;
    m_ie = ie_i;
    m_pu = pu_i;
    m_pd = pd_i & ~pu_i;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    out_i = N'($urandom); oe_i = N'($urandom); od_i = N'($urandom); ie_i = N'($urandom);
    pu_i = N'($urandom); pd_i = N'($urandom); filt_en_i = N'($urandom); filt_len_i = W'($urandom);
    irq_rise_en_i = N'($urandom); irq_fall_en_i = N'($urandom); irq_clr_i = N'($urandom);
    pad_c_i = N'($urandom);
    repeat (3) @(posedge clk_i);
    #1;
    checks++;
    if ({pad_i_o, pad_oe_o, pad_ie_o, pad_pu_o, pad_pd_o, in_o, irq_status_o, irq_o} !== '0)
      begin failures++; $display("FAIL reset_outputs: got %h expected 0",
        {pad_i_o, pad_oe_o, pad_ie_o, pad_pu_o, pad_pd_o, in_o, irq_status_o, irq_o}); end
    model_reset();
    set_defaults();
    irq_rise_en_i = '1; irq_fall_en_i = '1;
    rst_ni = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if ({irq_status_o, irq_o} !== {N'(0), 1'b0})
        begin failures++; $display("FAIL reset_release_irq cycle %0d: got status=%h irq=%b expected 0", c, irq_status_o, irq_o); end
    end
    irq_rise_en_i = '0; irq_fall_en_i = '0;
  endtask

  task automatic test_drive();
    oe_i = '1; out_i = '1; od_i = '0;
    #1;
    checks++;
    if (pad_oe_o !== '0) begin failures++; $display("FAIL drive_latency: got pad_oe=%h expected 00", pad_oe_o); end
    step();
    checks++;
    if ({pad_oe_o, pad_i_o} !== {8'hFF, 8'hFF}) begin failures++; $display("FAIL drive_pushpull: got oe=%h i=%h expected ff ff", pad_oe_o, pad_i_o); end
    od_i = '1; out_i = '1;
    step();
    checks++;
    if ({pad_oe_o, pad_i_o} !== {8'h00, 8'h00}) begin failures++; $display("FAIL drive_od_high: got oe=%h i=%h expected 00 00", pad_oe_o, pad_i_o); end
    od_i = '1; out_i = '0;
    step();
    checks++;
    if ({pad_oe_o, pad_i_o} !== {8'hFF, 8'h00}) begin failures++; $display("FAIL drive_od_low: got oe=%h i=%h expected ff 00", pad_oe_o, pad_i_o); end
    od_i = 8'h0F; out_i = 8'h33; oe_i = 8'h55;
    step();
    checks++;
    if ({pad_oe_o, pad_i_o} !== {8'h54, 8'h30}) begin failures++; $display("FAIL drive_mixed: got oe=%h i=%h expected 54 30", pad_oe_o, pad_i_o); end
    out_i = '0; oe_i = '0; od_i = '0;
  endtask

  task automatic test_pulls();
    pu_i = '1; pd_i = '1;
    step();
    checks++;
    if ({pad_pu_o, pad_pd_o} !== {8'hFF, 8'h00}) begin failures++; $display("FAIL pulls_both: got pu=%h pd=%h expected ff 00", pad_pu_o, pad_pd_o); end
    pu_i = '0; pd_i = '1;
    step();
    checks++;
    if ({pad_pu_o, pad_pd_o} !== {8'h00, 8'hFF}) begin failures++; $display("FAIL pulls_down: got pu=%h pd=%h expected 00 ff", pad_pu_o, pad_pd_o); end
    pu_i = 8'h0F; pd_i = 8'h3C;
    step();
    checks++;
    if ({pad_pu_o, pad_pd_o} !== {8'h0F, 8'h30}) begin failures++; $display("FAIL pulls_mixed: got pu=%h pd=%h expected 0f 30", pad_pu_o, pad_pd_o); end
    pu_i = '0; pd_i = '0;
  endtask

  task automatic test_filter();
    int k;
    logic seen;
    filt_en_i = '1; filt_len_i = 4'd4; pad_c_i = '0;
    repeat (4) step();
    seen = 1'b0;
    pad_c_i = '1;
    for (int c = 0; c < 13; c++) begin
      if (c == 3) pad_c_i = '0;
      step();
      if (in_o[0]) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin failures++; $display("FAIL filter_glitch: got in_o high=%b expected 0", seen); end
    pad_c_i = '1; k = -1;
    for (int c = 1; c <= 20 && k < 0; c++) begin
      step();
      if (in_o[0]) k = c;
    end
    pad_c_i = '0;
    checks++;
    if (k != 6) begin failures++; $display("FAIL filter_rise_latency: got %0d cycles expected 6", k); end
    k = -1;
    for (int c = 1; c <= 20 && k < 0; c++) begin
      step();
      if (!in_o[0]) k = c;
    end
    checks++;
    if (k != 6) begin failures++; $display("FAIL filter_fall_latency: got %0d cycles expected 6", k); end
    filt_en_i = '0; filt_len_i = '0;
  endtask

  task automatic test_irq();
    int k;
    irq_rise_en_i = '1; irq_fall_en_i = '0; irq_clr_i = '1;
    step();
    irq_clr_i = '0;
    pad_c_i = 8'h01; k = -1;
    for (int c = 1; c <= 10 && k < 0; c++) begin
      step();
      if (irq_o) k = c;
    end
    checks++;
    if (k != 4) begin failures++; $display("FAIL irq_rise_latency: got %0d cycles expected 4", k); end
    checks++;
    if (irq_status_o !== 8'h01) begin failures++; $display("FAIL irq_rise_status: got %h expected 01", irq_status_o); end
    irq_clr_i = 8'h01;
    step();
    irq_clr_i = '0;
    checks++;
    if ({irq_status_o, irq_o} !== {8'h00, 1'b0}) begin failures++; $display("FAIL irq_clear: got status=%h irq=%b expected 00 0", irq_status_o, irq_o); end
    pad_c_i = '0;
    repeat (6) step();
    checks++;
    if ({irq_status_o, in_o} !== 16'h0000) begin failures++; $display("FAIL irq_fall_masked: got status=%h in=%h expected 00 00", irq_status_o, in_o); end
    pad_c_i = 8'h01;
    repeat (3) step();
    irq_clr_i = 8'h01;
    step();
    irq_clr_i = '0;
    checks++;
    if ({irq_status_o, irq_o} !== {8'h01, 1'b1}) begin failures++; $display("FAIL irq_set_wins: got status=%h irq=%b expected 01 1", irq_status_o, irq_o); end
    irq_rise_en_i = '0;
    step();
    checks++;
    if (irq_status_o !== 8'h01) begin failures++; $display("FAIL irq_sticky_disable: got %h expected 01", irq_status_o); end
    pad_c_i = '0; irq_clr_i = '1;
    repeat (6) step();
    irq_clr_i = '0;
  endtask

  task automatic test_unfiltered();
    int k;
    filt_en_i = '0; pad_c_i = '1; k = -1;
    for (int c = 1; c <= 10 && k < 0; c++) begin
      step();
      if (in_o === 8'hFF) k = c;
    end
    checks++;
    if (k != 3) begin failures++; $display("FAIL unfilt_rise_latency: got %0d cycles expected 3", k); end
    pad_c_i = '0; k = -1;
    for (int c = 1; c <= 10 && k < 0; c++) begin
      step();
      if (in_o === 8'h00) k = c;
    end
    checks++;
    if (k != 3) begin failures++; $display("FAIL unfilt_fall_latency: got %0d cycles expected 3", k); end
    pad_c_i = '1;
    repeat (4) step();
    irq_fall_en_i = '1; irq_clr_i = '1;
    step();
    irq_clr_i = '0;
    ie_i = '0; k = -1;
    for (int c = 1; c <= 10 && k < 0; c++) begin
      step();
      if (in_o === 8'h00) k = c;
    end
    checks++;
    if (k != 4) begin failures++; $display("FAIL ie_off_latency: got %0d cycles expected 4", k); end
    step();
    checks++;
    if ({irq_status_o, irq_o} !== {8'hFF, 1'b1}) begin failures++; $display("FAIL ie_off_fall_irq: got status=%h irq=%b expected ff 1", irq_status_o, irq_o); end
    ie_i = '1; pad_c_i = '0; irq_fall_en_i = '0; irq_clr_i = '1;
    repeat (5) step();
    irq_clr_i = '0;
  endtask

  task automatic test_random();
    for (int ph = 0; ph < 4; ph++) begin
      filt_en_i     = N'($urandom);
      filt_len_i    = W'($urandom_range(0, 6));
      irq_rise_en_i = N'($urandom);
      irq_fall_en_i = N'($urandom);
      for (int c = 0; c < 150; c++) begin
        out_i = N'($urandom); oe_i = N'($urandom); od_i = N'($urandom);
        pu_i = N'($urandom); pd_i = N'($urandom);
        if ($urandom_range(0, 15) == 0) ie_i = N'($urandom);
        if (c == 75) filt_len_i = W'($urandom_range(0, 6));
        pad_c_i   = pad_c_i ^ (N'($urandom) & N'($urandom));
        irq_clr_i = ($urandom_range(0, 7) == 0) ? N'($urandom) : N'(0);
        step();
        checks++;
        if ({pad_i_o, pad_oe_o, pad_ie_o, pad_pu_o, pad_pd_o} !== {m_i, m_oe, m_ie, m_pu, m_pd})
          begin failures++; $display("FAIL rand_pad phase %0d cycle %0d: got %h expected %h", ph, c,
            {pad_i_o, pad_oe_o, pad_ie_o, pad_pu_o, pad_pd_o}, {m_i, m_oe, m_ie, m_pu, m_pd}); end
        checks++;
        if (in_o !== m_in)
          begin failures++; $display("FAIL rand_in phase %0d cycle %0d: got %h expected %h", ph, c, in_o, m_in); end
        checks++;
        if ({irq_status_o, irq_o} !== {m_st, m_irq})
          begin failures++; $display("FAIL rand_irq phase %0d cycle %0d: got status=%h irq=%b expected %h %b",
            ph, c, irq_status_o, irq_o, m_st, m_irq); end
      end
    end
  endtask

  task automatic test_reset_mid();
    filt_en_i = '1; filt_len_i = 4'd5; irq_rise_en_i = '1; irq_fall_en_i = '1;
    oe_i = '1; out_i = 8'hA5; pu_i = '1;
    for (int c = 0; c < 10; c++) begin
      pad_c_i = N'($urandom);
      step();
    end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++;
    if ({pad_i_o, pad_oe_o, pad_ie_o, pad_pu_o, pad_pd_o, in_o, irq_status_o, irq_o} !== '0)
      begin failures++; $display("FAIL reset_mid_outputs: got %h expected 0",
        {pad_i_o, pad_oe_o, pad_ie_o, pad_pu_o, pad_pd_o, in_o, irq_status_o, irq_o}); end
    model_reset();
    repeat (2) step();
    pad_c_i = '0;
    rst_ni = 1'b1;
    for (int c = 0; c < 20; c++) begin
      step();
      checks++;
      if ({in_o, irq_status_o, irq_o} !== {m_in, m_st, m_irq} || irq_o !== 1'b0)
        begin failures++; $display("FAIL reset_mid_release cycle %0d: got in=%h status=%h irq=%b expected 00 00 0",
          c, in_o, irq_status_o, irq_o); end
    end
  endtask

  initial begin
    model_reset();
    set_defaults();
    test_reset();
    test_drive();
    test_pulls();
    test_filter();
    test_irq();
    test_unfiltered();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
